// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - DMCtrl access-size/sign encodings used by datamemory (DM_B .. DM_HU)
//   - dmctrl_valid(): true for the five legal DMCtrl codes
//   - dmarb_state_t: arbiter FSM states
//   - port_id_t: identifies the requester that owns the current access
package dmem_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } dmarb_state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_id_t;

  function automatic logic dmctrl_valid(input logic [2:0] ctrl);
    return (ctrl == DM_B) || (ctrl == DM_H) || (ctrl == DM_W) ||
           (ctrl == DM_BU) || (ctrl == DM_HU);
  endfunction

endpackage

// File: rtl/dmem_prio_sel.sv
// Fixed-priority winner select with starvation protection for the low-priority port.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_en                  arbitration window open (arbiter idle)
//   i_a_valid, i_b_valid  request valid from port A (high priority) and port B
//   o_a_ready, o_b_ready  grant/handshake strobe per port; never both high
module dmem_prio_sel #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_a_valid,
  input  logic i_b_valid,
  output logic o_a_ready,
  output logic o_b_ready
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            w_force_b;

  // Port B is forced through once A has won Limit times in a row while B waited.
  assign w_force_b = i_b_valid && (r_cnt == Limit);
  assign o_a_ready = i_en && i_a_valid && !w_force_b;
  assign o_b_ready = i_en && i_b_valid && (w_force_b || !i_a_valid);

  always_comb begin
    w_cnt_d = r_cnt;
    if (o_a_ready) begin
      if (!i_b_valid) begin
        w_cnt_d = '0;
      end else if (r_cnt != Limit) begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end else if (o_b_ready) begin
      w_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port datamemory. Each accepted request is
// driven to memory for exactly one cycle (ACCESS) and returned through a response
// handshake (RESP). Port A has priority; dmem_prio_sel guarantees port B progress.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   A*/B* Req{Valid,Ready}       request handshake per port
//   A*/B* Address/DataWr/DMCtrl/DMWr  request payload (datamemory encoding)
//   A*/B* Rsp{Valid,Ready}       response handshake per port
//   A*/B* DataRd, RspErr         load data (0 for stores/errors), reject flag
//   Mem*                         datamemory interface; MemDataRd is combinational
// Build option: define DMEM_ARBITER_ALIGN_CHECK_EN to reject misaligned H/HU/W accesses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AReqValid,
  output logic              AReqReady,
  input  logic [ADDR_W-1:0] AAddress,
  input  logic [DATA_W-1:0] ADataWr,
  input  logic [2:0]        ADMCtrl,
  input  logic              ADMWr,
  output logic              ARspValid,
  input  logic              ARspReady,
  output logic [DATA_W-1:0] ADataRd,
  output logic              ARspErr,
  input  logic              BReqValid,
  output logic              BReqReady,
  input  logic [ADDR_W-1:0] BAddress,
  input  logic [DATA_W-1:0] BDataWr,
  input  logic [2:0]        BDMCtrl,
  input  logic              BDMWr,
  output logic              BRspValid,
  input  logic              BRspReady,
  output logic [DATA_W-1:0] BDataRd,
  output logic              BRspErr,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataWr,
  output logic [2:0]        MemDMCtrl,
  output logic              MemDMWr,
  input  logic [DATA_W-1:0] MemDataRd
);

  dmarb_state_t      r_state, w_state_d;
  port_id_t          r_port;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_ctrl;
  logic              r_wr;
  logic [DATA_W-1:0] r_rdata;

  logic              w_grant_en, w_a_ready, w_b_ready, w_hs;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [2:0]        w_sel_ctrl;
  logic              w_sel_wr;
  logic              w_misalign, w_req_err, w_rsp_hs;

  // Ready is gated by rst_n so no grant is visible while reset is asserted.
  assign w_grant_en = (r_state == StIdle) && rst_n;

  dmem_prio_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_grant_en),
    .i_a_valid(AReqValid),
    .i_b_valid(BReqValid),
    .o_a_ready(w_a_ready),
    .o_b_ready(w_b_ready)
  );

  assign AReqReady   = w_a_ready;
  assign BReqReady   = w_b_ready;
  assign w_hs        = w_a_ready || w_b_ready;

  assign w_sel_addr  = w_b_ready ? BAddress : AAddress;
  assign w_sel_wdata = w_b_ready ? BDataWr  : ADataWr;
  assign w_sel_ctrl  = w_b_ready ? BDMCtrl  : ADMCtrl;
  assign w_sel_wr    = w_b_ready ? BDMWr    : ADMWr;

`ifdef DMEM_ARBITER_ALIGN_CHECK_EN
  assign w_misalign = (((w_sel_ctrl == DM_H) || (w_sel_ctrl == DM_HU)) && w_sel_addr[0]) ||
                      ((w_sel_ctrl == DM_W) && (w_sel_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = !dmctrl_valid(w_sel_ctrl) || w_misalign;
  assign w_rsp_hs  = (r_state == StResp) && ((r_port == PORT_A) ? ARspReady : BRspReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_hs) w_state_d = w_req_err ? StResp : StAccess;
      StAccess: w_state_d = StResp;
      StResp:   if (w_rsp_hs) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Memory-side latches only load for accepted, error-free requests so the Mem* buses
  // keep the last real access while idle or while an errored request is answered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port  <= PORT_A;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ctrl  <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_hs) begin
        r_port  <= w_b_ready ? PORT_B : PORT_A;
        r_err   <= w_req_err;
        r_rdata <= '0;
        if (!w_req_err) begin
          r_addr  <= w_sel_addr;
          r_wdata <= w_sel_wdata;
          r_ctrl  <= w_sel_ctrl;
          r_wr    <= w_sel_wr;
        end
      end
      if ((r_state == StAccess) && !r_wr) begin
        r_rdata <= MemDataRd;
      end
    end
  end

  assign MemAddress = r_addr;
  assign MemDataWr  = r_wdata;
  assign MemDMCtrl  = r_ctrl;
  assign MemDMWr    = (r_state == StAccess) && r_wr;

  assign ARspValid  = (r_state == StResp) && (r_port == PORT_A);
  assign BRspValid  = (r_state == StResp) && (r_port == PORT_B);
  assign ARspErr    = ARspValid && r_err;
  assign BRspErr    = BRspValid && r_err;
  assign ADataRd    = ARspValid ? r_rdata : '0;
  assign BDataRd    = BRspValid ? r_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_pkg::*;

`ifdef DMEM_ARBITER_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic clk, rst_n;
  logic AReqValid, AReqReady, ADMWr, ARspValid, ARspReady, ARspErr;
  logic BReqValid, BReqReady, BDMWr, BRspValid, BRspReady, BRspErr;
  logic [31:0] AAddress, ADataWr, ADataRd, BAddress, BDataWr, BDataRd;
  logic [2:0] ADMCtrl, BDMCtrl, MemDMCtrl;
  logic [31:0] MemAddress, MemDataWr, MemDataRd;
  logic MemDMWr;

  int n_vec = 0;
  int n_err = 0;
  int wr_pulses = 0;
  string cur_tag = "init";

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .AReqValid(AReqValid), .AReqReady(AReqReady), .AAddress(AAddress), .ADataWr(ADataWr),
    .ADMCtrl(ADMCtrl), .ADMWr(ADMWr), .ARspValid(ARspValid), .ARspReady(ARspReady),
    .ADataRd(ADataRd), .ARspErr(ARspErr),
    .BReqValid(BReqValid), .BReqReady(BReqReady), .BAddress(BAddress), .BDataWr(BDataWr),
    .BDMCtrl(BDMCtrl), .BDMWr(BDMWr), .BRspValid(BRspValid), .BRspReady(BRspReady),
    .BDataRd(BDataRd), .BRspErr(BRspErr),
    .MemAddress(MemAddress), .MemDataWr(MemDataWr), .MemDMCtrl(MemDMCtrl),
    .MemDMWr(MemDMWr), .MemDataRd(MemDataRd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datamemory stand-in: byte array, little-endian, unaligned-capable, combinational read.
  logic [7:0] env_mem [32] = '{default: 8'h00};
  logic [7:0] ref_mem [32] = '{default: 8'h00};
  logic [4:0] env_a;
  assign env_a = MemAddress[4:0];

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] c);
    case (c)
      DM_B:    return {{24{raw[7]}}, raw[7:0]};
      DM_H:    return {{16{raw[15]}}, raw[15:0]};
      DM_BU:   return {24'h0, raw[7:0]};
      DM_HU:   return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_comb begin
    MemDataRd = ext({env_mem[env_a + 5'd3], env_mem[env_a + 5'd2],
                     env_mem[env_a + 5'd1], env_mem[env_a]}, MemDMCtrl);
  end

  always @(posedge clk) begin
    if (MemDMWr) begin
      env_mem[env_a] <= MemDataWr[7:0];
      if (MemDMCtrl[1:0] != 2'b00) env_mem[env_a + 5'd1] <= MemDataWr[15:8];
      if (MemDMCtrl[1:0] == 2'b10) begin
        env_mem[env_a + 5'd2] <= MemDataWr[23:16];
        env_mem[env_a + 5'd3] <= MemDataWr[31:24];
      end
      wr_pulses <= wr_pulses + 1;
    end
  end

  // Reference: what a requester should observe for one access, from the access rules alone.
  task automatic model(input logic [31:0] a, d, input logic [2:0] c, input bit w,
                       output logic [31:0] rd, output bit er);
    int nb;
    logic [31:0] raw;
    logic [4:0] idx;
    er = !(c inside {DM_B, DM_H, DM_W, DM_BU, DM_HU});
    if (AlignChk) er = er || (((c == DM_H) || (c == DM_HU)) && a[0]) ||
                       ((c == DM_W) && (a[1:0] != 2'b00));
    nb = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
    rd = 32'h0;
    raw = 32'h0;
    if (!er) begin
      for (int k = 0; k < nb; k++) begin
        idx = a[4:0] + 5'(k);
        if (w) ref_mem[idx] = d[8*k +: 8];
        else raw[8*k +: 8] = ref_mem[idx];
      end
      if (!w) rd = ext(raw, c);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h expected %h", cur_tag, name, act, exp);
    end
  endtask

  task automatic set_req(input bit p, input bit v, input logic [31:0] a, d,
                         input logic [2:0] c, input bit w);
    if (!p) begin AReqValid = v; AAddress = a; ADataWr = d; ADMCtrl = c; ADMWr = w; end
    else    begin BReqValid = v; BAddress = a; BDataWr = d; BDMCtrl = c; BDMWr = w; end
  endtask

  task automatic set_rsp_ready(input bit p, input bit v);
    if (!p) ARspReady = v; else BRspReady = v;
  endtask

  function automatic logic rdy(input bit p);        return p ? BReqReady : AReqReady; endfunction
  function automatic logic rsp_valid(input bit p);  return p ? BRspValid : ARspValid; endfunction
  function automatic logic [31:0] rsp_data(input bit p); return p ? BDataRd : ADataRd; endfunction
  function automatic logic rsp_err(input bit p);    return p ? BRspErr : ARspErr; endfunction

  task automatic access(input bit p, input logic [31:0] a, d, input logic [2:0] c, input bit w,
                        input int hold, input logic [31:0] exp_rd, input bit exp_er);
    int waited, lat, w0;
    bit got;
    @(negedge clk);
    set_req(p, 1'b1, a, d, c, w);
    waited = 0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rdy(p)) begin got = 1'b1; break; end
      @(negedge clk);
      waited++;
    end
    chk("req_wait", waited, 0);
    if (!got) begin set_req(p, 1'b0, 0, 0, 3'b0, 1'b0); return; end
    w0 = wr_pulses;
    @(posedge clk);
    #1;
    set_req(p, 1'b0, 0, 0, 3'b0, 1'b0);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      lat++;
      if (rsp_valid(p)) begin got = 1'b1; break; end
      if (lat == 1) begin
        chk("mem_addr", MemAddress, a);
        chk("mem_ctrl", MemDMCtrl, c);
        chk("mem_wr", MemDMWr, w);
        if (w) chk("mem_wdata", MemDataWr, d);
      end
    end
    chk("rsp_latency", lat, exp_er ? 1 : 2);
    if (!got) return;
    chk("rsp_data", rsp_data(p), exp_rd);
    chk("rsp_err", rsp_err(p), exp_er);
    chk("other_rsp_valid", rsp_valid(!p), 0);
    if (hold > 0) begin
      set_req(!p, 1'b1, 32'h0, 32'h0, DM_W, 1'b0);
      #1;
      for (int h = 0; h < hold; h++) begin
        chk("hold_valid", rsp_valid(p), 1);
        chk("hold_data", rsp_data(p), exp_rd);
        chk("hold_err", rsp_err(p), exp_er);
        chk("hold_other_ready", rdy(!p), 0);
        @(negedge clk);
        #1;
      end
      set_req(!p, 1'b0, 0, 0, 3'b0, 1'b0);
    end
    set_rsp_ready(p, 1'b1);
    @(posedge clk);
    #1;
    set_rsp_ready(p, 1'b0);
    chk("rsp_done", rsp_valid(p), 0);
    chk("wr_pulses", wr_pulses - w0, (!exp_er && w) ? 1 : 0);
  endtask

  typedef struct {
    bit p; logic [31:0] a; logic [31:0] d; logic [2:0] c; bit w;
    int hold; logic [31:0] exp_rd; bit exp_er;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [31:0] mrd;
    bit mer;
    int grants[$];
    bit p, w;
    logic [31:0] a, d;
    logic [2:0] c;

    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 32'h0, 32'h0, DM_W, 1'b0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, DM_W, 1'b0);
    ARspReady = 1'b0;
    BRspReady = 1'b0;
    #2;
    cur_tag = "reset";
    chk("a_ready", AReqReady, 0);
    chk("a_rsp_valid", ARspValid, 0);
    chk("b_rsp_valid", BRspValid, 0);
    chk("mem_wr", MemDMWr, 0);
    chk("mem_addr", MemAddress, 0);
    chk("a_data", ADataRd, 0);
    AReqValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: stores/loads with size/sign variants, errors, a stalled response.
    tbl.push_back('{0, 32'd3,  32'h80000001, DM_W,   1, 0, 32'h0, AlignChk});
    tbl.push_back('{0, 32'd3,  32'h0, DM_W,  0, 0, AlignChk ? 32'h0 : 32'h80000001, AlignChk});
    tbl.push_back('{1, 32'd1,  32'h0000FFFE, DM_H,   1, 0, 32'h0, AlignChk});
    tbl.push_back('{1, 32'd1,  32'h0, DM_HU, 0, 0, AlignChk ? 32'h0 : 32'h0000FFFE, AlignChk});
    tbl.push_back('{1, 32'd1,  32'h0, DM_H,  0, 0, AlignChk ? 32'h0 : 32'hFFFFFFFE, AlignChk});
    tbl.push_back('{0, 32'd8,  32'h12345678, DM_W,   1, 0, 32'h0, 1'b0});
    tbl.push_back('{0, 32'd8,  32'h0,        DM_W,   0, 5, 32'h12345678, 1'b0});
    tbl.push_back('{1, 32'd8,  32'h0,        DM_B,   0, 0, 32'h00000078, 1'b0});
    tbl.push_back('{0, 32'd11, 32'h0,        DM_BU,  0, 0, 32'h00000012, 1'b0});
    tbl.push_back('{0, 32'd10, 32'h0,        DM_HU,  0, 0, 32'h00001234, 1'b0});
    tbl.push_back('{0, 32'd12, 32'h000000C3, DM_B,   1, 0, 32'h0, 1'b0});
    tbl.push_back('{1, 32'd12, 32'h0,        DM_B,   0, 0, 32'hFFFFFFC3, 1'b0});
    tbl.push_back('{1, 32'd12, 32'h0,        DM_BU,  0, 0, 32'h000000C3, 1'b0});
    tbl.push_back('{0, 32'd8,  32'hDEADBEEF, 3'b011, 1, 2, 32'h0, 1'b1});
    tbl.push_back('{1, 32'd8,  32'h0,        3'b110, 0, 0, 32'h0, 1'b1});
    tbl.push_back('{0, 32'd8,  32'hDEADBEEF, 3'b111, 1, 0, 32'h0, 1'b1});
    tbl.push_back('{1, 32'd8,  32'h0,        DM_W,   0, 0, 32'h12345678, 1'b0});
    foreach (tbl[i]) begin
      cur_tag = $sformatf("tbl%0d", i);
      model(tbl[i].a, tbl[i].d, tbl[i].c, tbl[i].w, mrd, mer);
      access(tbl[i].p, tbl[i].a, tbl[i].d, tbl[i].c, tbl[i].w, tbl[i].hold,
             tbl[i].exp_rd, tbl[i].exp_er);
    end

    // Both ports hammer continuously: B gets through after every 4 consecutive A grants.
    cur_tag = "starve";
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'd8, 32'h0, DM_W, 1'b0);
    set_req(1'b1, 1'b1, 32'd8, 32'h0, DM_W, 1'b0);
    ARspReady = 1'b1;
    BRspReady = 1'b1;
    for (int cyc = 0; cyc < 60 && grants.size() < 10; cyc++) begin
      #1;
      chk("one_ready", AReqReady & BReqReady, 0);
      if (AReqReady) grants.push_back(0);
      else if (BReqReady) grants.push_back(1);
      if (grants.size() < 10) @(negedge clk);
    end
    set_req(1'b0, 1'b0, 0, 0, 3'b0, 1'b0);
    set_req(1'b1, 1'b0, 0, 0, 3'b0, 1'b0);
    chk("grant_count", grants.size(), 10);
    foreach (grants[i]) chk($sformatf("grant%0d", i), grants[i], ((i % 5) == 4) ? 1 : 0);
    @(negedge clk);
    ARspReady = 1'b0;
    BRspReady = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during ACCESS of a store: everything drops at once, the store never lands.
    cur_tag = "midreset";
    set_req(1'b0, 1'b1, 32'd16, 32'hCAFEF00D, DM_W, 1'b1);
    #1;
    chk("a_ready", AReqReady, 1);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b1, 32'd16, 32'hCAFEF00D, DM_W, 1'b1);
    set_req(1'b1, 1'b1, 32'd20, 32'h0, DM_W, 1'b0);
    chk("in_access_wr", MemDMWr, 1);
    rst_n = 1'b0;
    #1;
    chk("a_ready", AReqReady, 0);
    chk("b_ready", BReqReady, 0);
    chk("mem_wr", MemDMWr, 0);
    chk("mem_addr", MemAddress, 0);
    chk("mem_wdata", MemDataWr, 0);
    chk("mem_ctrl", MemDMCtrl, 0);
    chk("a_rsp", ARspValid | ARspErr, 0);
    chk("b_rsp", BRspValid | BRspErr, 0);
    chk("rd_data", ADataRd | BDataRd, 0);
    set_req(1'b0, 1'b0, 0, 0, 3'b0, 1'b0);
    set_req(1'b1, 1'b0, 0, 0, 3'b0, 1'b0);
    ARspReady = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("no_stale_rsp", ARspValid | BRspValid, 0);
    end
    ARspReady = 1'b0;
    model(32'd16, 32'h0, DM_W, 1'b0, mrd, mer);
    access(1'b0, 32'd16, 32'h0, DM_W, 1'b0, 0, mrd, mer);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      p = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 27));
      d = $urandom;
      c = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      model(a, d, c, w, mrd, mer);
      access(p, a, d, c, w, int'($urandom_range(0, 2)), mrd, mer);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
